// File: rtl/llr_branch_buffer_pkg.sv
// Shared types and helpers for the LLR branch buffer: FSM state encoding,
// default depth and the modular index distance used by the read hit test.
package llr_branch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVF  = 2'd2
    } buf_state_t;

    localparam int DEPTH_LOG2_DEFAULT = 8;
    localparam int DEPTH              = 2 ** DEPTH_LOG2_DEFAULT;

    // (a - b) mod 2**w, computed on a 32-bit carrier so it serves any index width
    function automatic logic [31:0] mod_dist(input logic [31:0] a, input logic [31:0] b,
                                             input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/llr_branch_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds
// its output when no read is issued. Read-during-write returns the old word.
module branch_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/llr_branch_buffer.sv
// Packs the serial LLR stream into CODE_N-wide branch words held in a circular
// RAM with random-access reads. Optional stats ports: LLR_BRANCH_BUF_STATS_EN.
module llr_branch_buffer
    import llr_branch_buffer_pkg::*;
#(
    parameter int LLR_WIDTH    = 6,
    parameter int CODE_N       = 2,
    parameter int DEPTH_LOG2   = 8,
    parameter int IDX_WIDTH    = 16,
    parameter int AFULL_MARGIN = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sync,
    input  logic [LLR_WIDTH-1:0]          i_llr,
    input  logic                          i_llr_valid,
    input  logic                          i_rd_en,
    input  logic [IDX_WIDTH-1:0]          i_rd_idx,
    input  logic                          i_release,
    output logic [CODE_N*LLR_WIDTH-1:0]   o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_rd_miss,
    output logic [IDX_WIDTH-1:0]          o_head_idx,
    output logic [IDX_WIDTH-1:0]          o_tail_idx,
    output logic [DEPTH_LOG2:0]           o_count,
`ifdef LLR_BRANCH_BUF_STATS_EN
    output logic [DEPTH_LOG2:0]           o_max_fill,
    output logic [15:0]                   o_ovf_cnt,
`endif
    output logic                          o_afull,
    output logic                          o_overflow
);

    localparam int PW = (CODE_N > 1) ? $clog2(CODE_N) : 1;
    localparam logic [PW-1:0]         LAST = PW'(CODE_N - 1);
    localparam logic [DEPTH_LOG2:0]   FULL = (DEPTH_LOG2+1)'(2 ** DEPTH_LOG2);

    buf_state_t                          state;
    logic [IDX_WIDTH-1:0]                head, tail;
    logic [DEPTH_LOG2:0]                 count;
    logic [PW-1:0]                       pack_cnt;
    logic [CODE_N-1:0][LLR_WIDTH-1:0]    pack_buf;
    logic [CODE_N-1:0][LLR_WIDTH-1:0]    wr_word;
    logic                                rel, take, done, wr, ovf_ev, hit;
    logic [DEPTH_LOG2:0]                 free;

    assign rel    = i_release && (count != '0);
    assign take   = i_llr_valid && (state != IDLE) && !i_sync;
    assign done   = take && (pack_cnt == LAST);
    // A full buffer may still accept a branch if the same cycle frees one
    assign wr     = done && (state == RUN) && ((count != FULL) || rel);
    assign ovf_ev = done && (state == RUN) && (count == FULL) && !rel;
    assign hit    = mod_dist(32'(i_rd_idx), 32'(tail), IDX_WIDTH) < 32'(count);
    assign free   = FULL - count;

    always_comb begin
        wr_word = pack_buf;
        wr_word[CODE_N-1] = i_llr;
    end

    branch_ram #(
        .DATA_W (CODE_N*LLR_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (i_clk),
        .reset   (i_reset),
        .wr_en   (wr && !i_reset),
        .wr_addr (head[DEPTH_LOG2-1:0]),
        .wr_data (wr_word),
        .rd_en   (i_rd_en && hit && !i_reset),
        .rd_addr (i_rd_idx[DEPTH_LOG2-1:0]),
        .rd_data (o_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pack_cnt   <= '0;
            pack_buf   <= '0;
            o_rd_valid <= 1'b0;
            o_rd_miss  <= 1'b0;
            o_afull    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en && hit;
            o_rd_miss  <= i_rd_en && !hit;
            o_afull    <= 32'(free) <= AFULL_MARGIN;
            if (i_sync) begin
                state    <= RUN;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                pack_cnt <= '0;
            end else begin
                if (take) begin
                    pack_buf[pack_cnt] <= i_llr;
                    pack_cnt           <= done ? '0 : pack_cnt + PW'(1);
                end
                if (wr)  head <= head + IDX_WIDTH'(1);
                if (rel) tail <= tail + IDX_WIDTH'(1);
                if (wr && !rel)      count <= count + (DEPTH_LOG2+1)'(1);
                else if (rel && !wr) count <= count - (DEPTH_LOG2+1)'(1);
                if (ovf_ev) begin
                    state      <= OVF;
                    o_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_head_idx = head;
    assign o_tail_idx = tail;
    assign o_count    = count;

`ifdef LLR_BRANCH_BUF_STATS_EN
    // Dropped branches are still packed while in OVF so they can be counted
    logic drop;
    assign drop = done && ((state == OVF) || ovf_ev);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_max_fill <= '0;
            o_ovf_cnt  <= '0;
        end else begin
            if (count > o_max_fill) o_max_fill <= count;
            if (drop && (o_ovf_cnt != 16'hFFFF)) o_ovf_cnt <= o_ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_llr_branch_buffer.sv
// Directed bench for llr_branch_buffer with a queue-based reference model
// checked every cycle, plus hand-computed literal checks.
module tb_llr_branch_buffer;
    localparam int LW = 6, CN = 2, DL = 4, IW = 8, AM = 4;
    localparam int DEPTH = 16, IMOD = 256;

    logic          clk = 1'b0;
    logic          rst, sync, llr_valid, rd_en, rls;
    logic [LW-1:0] llr;
    logic [IW-1:0] rd_idx;
    logic [CN*LW-1:0] rd_data;
    logic          rd_valid, rd_miss, afull, overflow;
    logic [IW-1:0] head_idx, tail_idx;
    logic [DL:0]   count;
`ifdef LLR_BRANCH_BUF_STATS_EN
    logic [DL:0]   max_fill;
    logic [15:0]   ovf_cnt;
`endif

    always #5 clk = ~clk;

    llr_branch_buffer #(
        .LLR_WIDTH(LW), .CODE_N(CN), .DEPTH_LOG2(DL), .IDX_WIDTH(IW), .AFULL_MARGIN(AM)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_sync(sync), .i_llr(llr), .i_llr_valid(llr_valid),
        .i_rd_en(rd_en), .i_rd_idx(rd_idx), .i_release(rls),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_miss(rd_miss),
        .o_head_idx(head_idx), .o_tail_idx(tail_idx), .o_count(count),
`ifdef LLR_BRANCH_BUF_STATS_EN
        .o_max_fill(max_fill), .o_ovf_cnt(ovf_cnt),
`endif
        .o_afull(afull), .o_overflow(overflow)
    );

    int passed = 0, total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: stored branches as a queue, oldest first
    logic [CN*LW-1:0] m_mem[$];
    logic [LW-1:0]    m_part[$];
    int               m_head = 0, m_tail = 0, e_max = 0, e_ocnt = 0;
    bit               m_run = 0, m_ovfm = 0, m_ovf = 0;
    bit               e_valid = 0, e_miss = 0, e_afull = 0;
    logic [CN*LW-1:0] e_data = '0;

    task automatic tick();
        int pre, d;
        bit rel;
        logic [CN*LW-1:0] w;
        pre = m_mem.size();
        if (rst) begin
            m_mem.delete(); m_part.delete();
            m_head = 0; m_tail = 0; e_max = 0; e_ocnt = 0;
            m_run = 0; m_ovfm = 0; m_ovf = 0;
            e_valid = 0; e_miss = 0; e_afull = 0; e_data = '0;
        end else begin
            e_valid = 0; e_miss = 0;
            if (rd_en) begin
                d = (int'(rd_idx) - m_tail + IMOD) % IMOD;
                if (d < pre) begin e_valid = 1; e_data = m_mem[d]; end
                else e_miss = 1;
            end
            e_afull = (DEPTH - pre) <= AM;
            if (pre > e_max) e_max = pre;
            if (sync) begin
                m_run = 1; m_ovfm = 0; m_head = 0; m_tail = 0;
                m_mem.delete(); m_part.delete();
            end else begin
                rel = rls && pre > 0;
                if (rel) begin void'(m_mem.pop_front()); m_tail = (m_tail + 1) % IMOD; end
                if (llr_valid && m_run) begin
                    m_part.push_back(llr);
                    if (m_part.size() == CN) begin
                        w = '0;
                        for (int k = 0; k < CN; k++) w[k*LW +: LW] = m_part[k];
                        m_part.delete();
                        if (m_ovfm || (pre == DEPTH && !rel)) begin
                            m_ovfm = 1; m_ovf = 1;
                            if (e_ocnt < 65535) e_ocnt++;
                        end else begin
                            m_mem.push_back(w);
                            m_head = (m_head + 1) % IMOD;
                        end
                    end
                end
            end
        end
        @(posedge clk); #1;
        chk("rd_valid", rd_valid, e_valid);
        chk("rd_miss", rd_miss, e_miss);
        chk("rd_data", rd_data, e_data);
        chk("head", head_idx, m_head);
        chk("tail", tail_idx, m_tail);
        chk("count", count, m_mem.size());
        chk("afull", afull, e_afull);
        chk("overflow", overflow, m_ovf);
`ifdef LLR_BRANCH_BUF_STATS_EN
        chk("max_fill", max_fill, e_max);
        chk("ovf_cnt", ovf_cnt, e_ocnt);
`endif
    endtask

    task automatic drv(input bit v, input int l, input bit re, input int ix,
                       input bit rl, input bit sy);
        llr_valid = v; llr = LW'(l); rd_en = re; rd_idx = IW'(ix); rls = rl; sync = sy;
        tick();
    endtask

    initial begin
        rst = 1; sync = 0; llr_valid = 0; llr = '0; rd_en = 0; rd_idx = '0; rls = 0;
        tick(); tick();
        chk("reset_count", count, 0);
        chk("reset_head", head_idx, 0);
        rst = 0;
        drv(0, 0, 0, 0, 0, 0);

        // Basic packing and reads
        drv(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) drv(1, i, 0, 0, 0, 0);
        chk("lit_count4", count, 4);
        chk("lit_head4", head_idx, 4);
        drv(0, 0, 1, 2, 0, 0);
        chk("lit_rd2_valid", rd_valid, 1);
        chk("lit_rd2_data", rd_data, 12'h185);
        drv(0, 0, 1, 4, 0, 0);
        chk("lit_rd4_miss", rd_miss, 1);
        drv(0, 0, 1, 7, 0, 0);
        chk("lit_rd7_miss", rd_miss, 1);
        drv(0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 1, 0);
        drv(0, 0, 1, 1, 0, 0);
        chk("lit_rd1_miss", rd_miss, 1);
        drv(0, 0, 1, 2, 0, 0);
        chk("lit_rd2_hit", rd_valid, 1);
        chk("lit_rd2_hold", rd_data, 12'h185);

        // Full buffer: release and completion in the same cycle
        drv(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2*DEPTH; i++) drv(1, i + 20, 0, 0, 0, 0);
        chk("lit_full16", count, 16);
        drv(1, 3, 0, 0, 0, 0);
        drv(1, 4, 1, 0, 1, 0);
        chk("lit_fr_count", count, 16);
        chk("lit_fr_head", head_idx, 17);
        chk("lit_fr_tail", tail_idx, 1);
        chk("lit_fr_noovf", overflow, 0);

        // Overflow
        drv(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2*DEPTH; i++) drv(1, i, 0, 0, 0, 0);
        chk("lit_afull", afull, 1);
        drv(1, 40, 0, 0, 0, 0);
        drv(1, 41, 0, 0, 0, 0);
        chk("lit_ovf", overflow, 1);
        chk("lit_ovf_count", count, 16);
        chk("lit_ovf_head", head_idx, 16);
        drv(1, 42, 0, 0, 0, 0);
        drv(1, 43, 1, 3, 0, 0);
        chk("lit_ovf_rd", rd_valid, 1);
        drv(0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 0);

        // Sync discards partial branch and coinciding LLR
        drv(0, 0, 0, 0, 0, 1);
        drv(1, 9, 0, 0, 0, 0);
        drv(1, 10, 0, 0, 0, 1);
        chk("lit_sync_count", count, 0);
        chk("lit_sync_head", head_idx, 0);
        drv(1, 11, 0, 0, 0, 0);
        drv(1, 12, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0);
        chk("lit_sync_data", rd_data, 12'h30B);

        // Long stream with continuous release across the index wrap
        rst = 1; drv(0, 0, 0, 0, 0, 0); rst = 0;
        drv(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++) drv(1, int'($urandom_range(0, 63)), 1, m_tail, 1, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("lit_wrap_head", head_idx, 44);
`ifdef LLR_BRANCH_BUF_STATS_EN
        chk("lit_max_fill_le2", max_fill <= 2, 1);
        chk("lit_ovf_cnt0", ovf_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/llr_branch_buffer.md
Name: llr_branch_buffer

Overview:
- Sits directly downstream of llr_former and upstream of the Fano decoder core.
- Packs the serial LLR stream into branch words of CODE_N LLRs each and stores them in a circular RAM.
- Serves random-access branch reads so the decoder can move back and forth during search; the decoder frees the oldest branches explicitly.
- llr_former has no output back-pressure, so this block gives an early almost-full warning and records overflow.

Parameters:
- LLR_WIDTH, 6, width of one LLR (signed two's complement)
- CODE_N, 2, LLRs per branch (code rate 1/CODE_N); legal range 2..4
- DEPTH_LOG2, 8, log2 of buffer depth in branches
- IDX_WIDTH, 16, width of the absolute branch index; must be > DEPTH_LOG2
- AFULL_MARGIN, 16, almost-full asserts when free branches <= AFULL_MARGIN

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_sync  in  1  frame start; resets branch packing and indices
- i_llr  in  LLR_WIDTH  LLR from llr_former
- i_llr_valid  in  1  LLR strobe
- i_rd_en  in  1  decoder read request
- i_rd_idx  in  IDX_WIDTH  absolute branch index to read
- i_release  in  1  free the oldest stored branch
- o_rd_data  out  CODE_N*LLR_WIDTH  branch word; LLR k at bits [(k+1)*LLR_WIDTH-1 : k*LLR_WIDTH], k=0 arrives first
- o_rd_valid  out  1  read data valid
- o_rd_miss  out  1  requested index is not stored; decoder must stall
- o_head_idx  out  IDX_WIDTH  index of the next branch to be written
- o_tail_idx  out  IDX_WIDTH  oldest stored index
- o_count  out  DEPTH_LOG2+1  stored branches
- o_afull  out  1  almost full
- o_overflow  out  1  sticky overflow flag

Behaviour:
- Reset values:
  - all outputs 0
  - head, tail and count 0; packing counter 0
  - state IDLE
- States:
  - IDLE: LLRs are ignored. Go to RUN on i_sync, which resets indices.
  - RUN: normal operation.
  - OVF: entered when a branch completes while count == 2**DEPTH_LOG2. That branch is dropped and o_overflow is set. Writes are ignored; reads and releases still work. Leave only by i_reset or i_sync, both of which go to RUN with indices cleared.
- Packing:
  - The packing counter increments on i_llr_valid and wraps at CODE_N-1.
  - On the LLR that completes a branch, the word is written to RAM[head mod depth], head increments (wrapping modulo 2**IDX_WIDTH) and count increments.
- i_sync takes priority over i_llr_valid in the same cycle:
  - head = tail = 0, count = 0, packing cleared.
  - The LLR in that cycle is dropped; the first LLR after sync is LLR 0 of branch 0.
  - A partially packed branch is discarded.
- Release:
  - When count > 0, tail and count are updated by one (tail increments, count decrements).
  - Release with count == 0 is ignored.
  - Write and release in the same cycle: head and tail both advance, count is unchanged. Full plus release plus write is legal and is not an overflow.
- Read (latency 1):
  - The request is valid when (i_rd_idx - tail) mod 2**IDX_WIDTH < count.
  - On a valid request, o_rd_valid=1 with data next cycle.
  - Otherwise o_rd_miss=1 next cycle, o_rd_valid=0, and o_rd_data holds its previous value.
  - Hit/miss is judged on the pre-update head/tail of the request cycle.
  - A read of the branch being written in the same cycle is a miss.
  - o_rd_valid and o_rd_miss are single-cycle pulses and are mutually exclusive.
- o_afull = (2**DEPTH_LOG2 - count) <= AFULL_MARGIN; registered, one cycle after count changes.
- RAM is a single write port plus single registered read port, inferable as block RAM.

Optional Feature:
- Macro: LLR_BRANCH_BUF_STATS_EN.
- Defined: adds
  - o_max_fill (DEPTH_LOG2+1), the high-water mark of count;
  - o_ovf_cnt (16), the number of dropped branches, saturating at 0xFFFF.
  - Both are cleared by i_reset only; i_sync does not clear them.
- Undefined: neither port exists and no logic is added. Core behaviour is identical.

Decomposition:
- Package llr_branch_buffer_pkg:
  - state enum (IDLE/RUN/OVF)
  - localparam DEPTH = 2**DEPTH_LOG2
  - the modular-distance function used for the hit test
- One sub-module, branch_ram: simple dual-port RAM, 1 write, 1 registered read, parameterised by data width and depth.
- Packing, pointers, FSM and flags stay in the top.

Test Plan:
- Reset, then i_sync, then 8 LLRs 1..8 with CODE_N=2 → count=4, head=4. Read idx 2 → next cycle o_rd_valid=1 and o_rd_data={8'… LLR6, LLR5}, i.e. lower field 5, upper field 6.
- Read idx 4 (== head) and idx 7 → o_rd_miss pulse, o_rd_valid=0. Release ×2, then read idx 1 → miss; read idx 2 → hit.
- DEPTH_LOG2=4: write 16 branches, no release → o_afull rises at count 16-AFULL_MARGIN (margin=4: count 12). The 17th branch → o_overflow=1, state OVF, count stays 16, head=16.
- Full buffer with release and branch completion in the same cycle → no overflow, count stays 16, head and tail each +1.
- Send 1 LLR (half branch), then i_sync coinciding with an LLR → count=0, head=0. The next 2 LLRs form branch 0 and contain neither dropped LLR.
- IDX_WIDTH=8, DEPTH_LOG2=4: stream 300 branches with continuous release → head wraps 255→0. A read of tail index across the wrap hits with the correct data. With the stats macro defined, o_max_fill ≤ 2 and o_ovf_cnt=0.
